// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1-to-4 demux sequencing controller.
package demux_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic MODE_ADDR = 1'b0;
   localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/demux_1x4.sv
// 1-to-4 one-hot demultiplexer: routes input f to output y[s] when enabled.
module demux_1x4 (
   input  logic       f,
   input  logic       en,
   input  logic [1:0] s,
   output logic [3:0] y
);

   always_comb begin
      y = 4'b0000;
      if (f && en) y[s] = 1'b1;
   end

endmodule

// File: rtl/demux_1x4_sched.sv
// Single-entry holding register that steers a valid/ready stream onto one of four
// channels, by address or round-robin, with a programmable stall timeout.
//
// state | meaning
// ------+------------------------------------------
// IDLE  | holding register empty
// BUSY  | item held for channel s, waiting for y_ready[s]
module demux_1x4_sched
   import demux_sched_pkg::*;
#(
   parameter int W   = 8,
   parameter int TMO = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         mode,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic [1:0]   in_sel,
   output logic [3:0]   y_valid,
   input  logic [3:0]   y_ready,
   output logic [W-1:0] y_data,
   output logic [1:0]   s,
   output logic         busy,
   output logic         drop
);

   localparam int            CW     = (TMO > 0) ? $clog2(TMO + 1) : 1;
   localparam logic [CW-1:0] TMO_C  = CW'(TMO);
   localparam logic          TMO_EN = (TMO != 0);

   state_t          state_q, state_d;
   logic [W-1:0]    data_q, data_d;
   logic [1:0]      s_q, s_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            fire;
   logic            timeout_hit;
   logic            accept;
   logic [1:0]      dest;

   assign busy        = (state_q == BUSY);
   assign fire        = busy & y_ready[s_q];
   assign timeout_hit = TMO_EN & busy & ~fire & (cnt_q == TMO_C);
   // Held low during reset so the producer never sees a handshake that reset discards.
   assign in_ready    = en & (~busy | fire) & ~timeout_hit & ~rst;
   assign accept      = in_valid & in_ready;
   assign drop        = timeout_hit & ~rst;
   assign dest        = (mode == MODE_RR) ? ptr_q : in_sel;

   assign y_data = data_q;
   assign s      = s_q;

   demux_1x4 u_demux (
      .f  (busy),
      .en (1'b1),
      .s  (s_q),
      .y  (y_valid)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      s_d     = s_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = BUSY;
         data_d  = in_data;
         s_d     = dest;
         cnt_d   = '0;
         if (mode == MODE_RR) ptr_d = ptr_q + 2'd1;
      end else if (fire || timeout_hit) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (busy && (cnt_q != TMO_C)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         s_q     <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         s_q     <= s_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_demux_1x4_sched.sv
// Scoreboard bench for demux_1x4_sched: directed scenarios followed by random traffic.
module tb_demux_1x4_sched;

   localparam int W   = 8;
   localparam int TMO = 15;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b1;
   logic         mode = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic [1:0]   in_sel = 2'd0;
   logic [3:0]   y_valid;
   logic [3:0]   y_ready = 4'b0000;
   logic [W-1:0] y_data;
   logic [1:0]   s;
   logic         busy;
   logic         drop;

   demux_1x4_sched #(.W(W), .TMO(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y_data   (y_data),
      .s        (s),
      .busy     (busy),
      .drop     (drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   d;
      logic [W-1:0] v;
   } item_t;

   item_t        sb_q[$];
   int           stall_cnt = 0;
   logic [1:0]   m_ptr = 2'd0;
   logic [1:0]   last_s = 2'd0;
   logic [W-1:0] last_d = '0;
   int           vectors = 0;
   int           miscompares = 0;

   logic         m_busy, m_fire, m_tmo, m_ready;
   logic [3:0]   m_yv;
   logic [1:0]   m_s;
   logic [W-1:0] m_yd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: compares DUT against the reference model each cycle, then advances the model.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
         chk("rst_drop", {31'd0, drop}, 32'd0);
         sb_q.delete();
         stall_cnt = 0;
         m_ptr     = 2'd0;
         last_s    = 2'd0;
         last_d    = '0;
      end else begin
         m_busy = (sb_q.size() > 0);
         m_s    = m_busy ? sb_q[0].d : last_s;
         m_yd   = m_busy ? sb_q[0].v : last_d;
         m_yv   = m_busy ? (4'b0001 << m_s) : 4'b0000;
         m_fire = m_busy && y_ready[m_s];
         m_tmo  = (TMO != 0) && m_busy && !m_fire && (stall_cnt == TMO);
         m_ready = en && (!m_busy || m_fire) && !m_tmo;

         chk("busy", {31'd0, busy}, {31'd0, m_busy});
         chk("y_valid", {28'd0, y_valid}, {28'd0, m_yv});
         chk("s", {30'd0, s}, {30'd0, m_s});
         chk("y_data", {24'd0, y_data}, {24'd0, m_yd});
         chk("drop", {31'd0, drop}, {31'd0, m_tmo});
         chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});

         if (m_fire || m_tmo) begin
            void'(sb_q.pop_front());
            stall_cnt = 0;
         end else if (m_busy && stall_cnt < TMO) begin
            stall_cnt++;
         end

         if (in_valid && m_ready) begin
            item_t it;
            it.d = mode ? m_ptr : in_sel;
            it.v = in_data;
            sb_q.push_back(it);
            stall_cnt = 0;
            last_s    = it.d;
            last_d    = it.v;
            if (mode) m_ptr = m_ptr + 2'd1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int burst;
      burst = 0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Addressed delivery to channel 2
      mode = 1'b0; in_sel = 2'd2; in_data = 8'hA5; y_ready = 4'b0100; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();

      // Round-robin wrap, continuous readiness
      mode = 1'b1; y_ready = 4'hF;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = W'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      // ptr should now be 2: next rr item lands on channel 2
      in_valid = 1'b1; in_data = 8'h6C;
      tick();
      in_valid = 1'b0;
      tick();

      // Backpressure on channel 1, then back-to-back accept on release
      mode = 1'b0; y_ready = 4'b0000;
      in_sel = 2'd1; in_data = 8'h11; in_valid = 1'b1;
      tick();
      in_sel = 2'd0; in_data = 8'h22;
      repeat (5) tick();
      y_ready = 4'b0011;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();

      // Timeout drop on channel 3
      y_ready = 4'b0000; in_sel = 2'd3; in_data = 8'h33; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (TMO + 4) tick();

      // Ready arrives on the expiry cycle: delivered, not dropped
      in_data = 8'h44; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (TMO) tick();
      y_ready = 4'b1000;
      tick();
      y_ready = 4'b0000;
      tick();

      // en low: held item still delivered, no new accept until en returns
      in_sel = 2'd2; in_data = 8'h55; in_valid = 1'b1;
      tick();
      en = 1'b0; in_sel = 2'd1; in_data = 8'h66;
      repeat (3) tick();
      y_ready = 4'b0110;
      repeat (2) tick();
      en = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      y_ready = 4'b0000;

      // Reset while busy
      mode = 1'b1; in_data = 8'h77; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (2) tick();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 299) == 0);
         en       = ($urandom_range(0, 9) != 0);
         mode     = 1'($urandom_range(0, 1));
         in_valid = ($urandom_range(0, 9) < 7);
         in_data  = W'($urandom);
         in_sel   = 2'($urandom_range(0, 3));
         if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(10, 25);
         if (burst > 0) begin
            y_ready = 4'b0000;
            burst--;
         end else begin
            y_ready = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
         end
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; y_ready = 4'hF;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/demux_1x4_sched.md
# demux_1x4_sched

Sequencing controller that feeds a single valid/ready input stream through a 1-to-4 demultiplexer onto four output channels. Each accepted item is held in one output register until the selected channel takes it. Destinations come from the item's own address or from a strict round-robin pointer. A programmable stall timeout discards items a channel never takes. The block sits between a single producer and four consumers and owns the demux select and enable.

## Interface
- W, 8, data width
- TMO, 15, stall timeout in cycles (0 = timeout disabled)
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  accept enable; low blocks new accepts only
- mode  in  1  0 = addressed (dest = in_sel), 1 = round-robin (dest = ptr)
- in_valid  in  1  producer has an item
- in_ready  out  1  block accepts this cycle
- in_data  in  W  item payload
- in_sel  in  2  destination in addressed mode
- y_valid  out  4  one-hot valid for held item, 0 when empty
- y_ready  in  4  per-channel ready
- y_data  out  W  shared payload bus, valid for channel s
- s  out  2  channel of held item
- busy  out  1  holding register occupied
- drop  out  1  one-cycle pulse: held item discarded by timeout

## Operation
- States: IDLE (empty), BUSY (item held for channel s).
- fire = busy & y_ready[s]. in_ready = en & (IDLE | fire) & ~timeout_hit.
- accept = in_valid & in_ready. On accept: load in_data and dest into the holding register, then go or stay BUSY, and clear the stall counter.
- dest = in_sel when mode = 0, ptr when mode = 1. `mode` is sampled at accept and does not affect an item already held.
- ptr advances by 1 mod 4 (3 -> 0) only on an accept in mode 1. The addressed mode leaves ptr unchanged.
- BUSY, fire, no accept -> IDLE. BUSY, fire, accept -> BUSY with the new item (back-to-back).
- Stall counter: width clog2(TMO+1). Increments each BUSY cycle without fire and saturates at TMO.
- timeout_hit = (TMO != 0) & BUSY & ~fire & (cnt == TMO). On timeout_hit: drop = 1, go to IDLE, no accept that cycle.
- fire wins over timeout in the same cycle. The item is delivered, not dropped.
- en low: no new accepts. A held item is still delivered or timed out normally.
- y_valid = one-hot(s) when busy, else 4'b0000. y_data holds the last loaded value, including while IDLE.
- Reset values: state IDLE, busy 0, y_valid 0, y_data 0, s 0, ptr 0, cnt 0, drop 0, in_ready 0 during reset.
- Reset mid-operation discards the held item without asserting drop.

## Timing
- Accept at edge k -> y_valid/y_data/s valid from cycle k+1. Latency is 1 cycle.
- Throughput is 1 item/cycle when the destination is continuously ready (fire and accept in the same cycle).
- in_ready is combinational from y_ready, state and cnt. There is no combinational path from in_valid to any output.
- A held item with its channel never ready is dropped at cycle k+1+TMO, with drop high for that one cycle.
- drop and in_ready are never high in the same cycle.

## Structure
- Package demux_sched_pkg holds the state enum {IDLE, BUSY} and the constants MODE_ADDR = 1'b0 and MODE_RR = 1'b1.
- Sub-module: instantiate the existing demux_1x4 to decode y_valid, with f = busy, en = 1, s = s, y = y_valid.
- All other logic lives in one always block for sequential state plus continuous assigns for in_ready, fire and timeout_hit.

## Test plan
- Addressed delivery: mode = 0, in_sel = 2, in_data = 8'hA5, y_ready = 4'b0100 -> y_valid = 4'b0100 and y_data = A5 one cycle after accept, then busy falls.
- Round-robin wrap: mode = 1, y_ready = 4'hF, 6 items 0..5 streamed -> s = 0,1,2,3,0,1 on consecutive cycles, in_ready held high, ptr = 2 at the end.
- Backpressure: hold y_ready[1] = 0 for 5 cycles with an item for channel 1 -> in_ready = 0 and y_data stable; release -> fire, and the next item is accepted in the same cycle.
- Timeout: TMO = 15, item for channel 3, y_ready = 0 -> drop pulses exactly 16 cycles after accept, busy = 0 next cycle. y_ready[3] rising on the expiry cycle -> delivered, no drop.
- en low: item held and en = 0 -> held item still delivered and in_ready stays 0. The next item is accepted only after en = 1.
- Reset mid-transfer: rst asserted while BUSY -> next cycle busy = 0, y_valid = 0, s = 0, ptr = 0, drop = 0.
